// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Board-level reset controller. After the user button is released it holds
// reset for a fixed time, waits until every PLL has been stably locked for
// LOCK_FILTER cycles, then releases NUM_CH active-low reset channels one at a
// time, STAGE_CYCLES apart (bit 0 first). Lock loss during release or run
// drops every channel and returns to WAIT_LOCK, and the event is counted.
// A software request restarts the whole sequence from HOLD.
//
// Ports
//   SYS_CLK            in   1          system clock, rising edge
//   user_reset_button  in   1          asynchronous active-high reset
//   pll_locked         in   NUM_LOCKS  PLL lock flags, asynchronous to SYS_CLK
//   sw_reset_req       in   1          1-cycle synchronous restart request
//   reset_n_out        out  NUM_CH     staged active-low resets, bit 0 first
//   sys_reset          out  1          registered, equals ~&reset_n_out
//   seq_done           out  1          high only in RUN
//   state_o            out  3          state encoding (HOLD=0 .. RUN=3)
//   lock_loss_cnt      out  8          saturating lock-loss event count
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int HOLD_US      = 1000,
    parameter int NUM_LOCKS    = 2,
    parameter int LOCK_FILTER  = 8,
    parameter int NUM_CH       = 4,
    parameter int STAGE_CYCLES = 16
) (
    input  logic                 SYS_CLK,
    input  logic                 user_reset_button,
    input  logic [NUM_LOCKS-1:0] pll_locked,
    input  logic                 sw_reset_req,
    output logic [NUM_CH-1:0]    reset_n_out,
    output logic                 sys_reset,
    output logic                 seq_done,
    output logic [2:0]           state_o,
    output logic [7:0]           lock_loss_cnt
);

    localparam int HOLD_CYCLES = (SYS_CLK_FREQ / 1_000_000) * HOLD_US;
    // One shared counter serves both the hold period and the stage spacing,
    // so it is sized for whichever terminal value is larger.
    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES - 1 : STAGE_CYCLES - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int LK_W    = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [LK_W-1:0]  LK_LAST    = LK_W'(LOCK_FILTER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [LK_W-1:0]      lk_cnt_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [NUM_LOCKS-1:0] lock_sync;
    logic                 all_lk;

    // Two-flop synchroniser per lock bit; the reset clears them so a fresh
    // sequence never sees a stale "locked" from before the button press.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LOCKS; gi++) begin : g_lock_sync
            logic sync1_reg;
            logic sync2_reg;
            always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
                if (user_reset_button) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= pll_locked[gi];
                    sync2_reg <= sync1_reg;
                end
            end
            assign lock_sync[gi] = sync2_reg;
        end
    endgenerate

    assign all_lk  = &lock_sync;
    assign state_o = state_reg;

    // Channels are only ever released in ascending order and all dropped
    // together, so sys_reset is low exactly while in RUN; it is therefore
    // driven alongside the transitions into and out of RUN, which keeps it
    // on the same edge as reset_n_out.
    always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
        if (user_reset_button) begin
            state_reg     <= ST_HOLD;
            cnt_reg       <= '0;
            lk_cnt_reg    <= '0;
            idx_reg       <= '0;
            reset_n_out   <= '0;
            sys_reset     <= 1'b1;
            seq_done      <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else if (sw_reset_req) begin
            // Software restart beats a simultaneous lock loss: no count.
            state_reg   <= ST_HOLD;
            cnt_reg     <= '0;
            lk_cnt_reg  <= '0;
            idx_reg     <= '0;
            reset_n_out <= '0;
            sys_reset   <= 1'b1;
            seq_done    <= 1'b0;
        end else if (!all_lk && (state_reg == ST_RELEASE || state_reg == ST_RUN)) begin
            // The hold period is not repeated after a lock loss.
            state_reg   <= ST_WAIT_LOCK;
            cnt_reg     <= '0;
            lk_cnt_reg  <= '0;
            idx_reg     <= '0;
            reset_n_out <= '0;
            sys_reset   <= 1'b1;
            seq_done    <= 1'b0;
            if (lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_LOCK;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!all_lk) begin
                        lk_cnt_reg <= '0;
                    end else if (lk_cnt_reg == LK_LAST) begin
                        lk_cnt_reg <= '0;
                        cnt_reg    <= '0;
                        idx_reg    <= '0;
                        state_reg  <= ST_RELEASE;
                    end else begin
                        lk_cnt_reg <= lk_cnt_reg + LK_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_reg == STAGE_LAST) begin
                        cnt_reg <= '0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (idx_reg == IDX_W'(k)) begin
                                reset_n_out[k] <= 1'b1;
                            end
                        end
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= ST_RUN;
                            seq_done  <= 1'b1;
                            sys_reset <= 1'b0;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Steady state; only an abort leaves it.
                end
                default: begin
                    state_reg <= ST_HOLD;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule
